// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that funnels NUM_REQ requester words
// into one shared FIFO write port. One write at most every two cycles; all
// outputs come straight from flops.
//
// Handshake: each requester raises i_req[k] with its word on i_data and holds
// both until it sees o_ack[k] for one cycle. o_ack[k] and o_fifo_write rise
// together on the same edge, so the ack means "your word is on the FIFO port
// this cycle". The FIFO side accepts a write only when i_fifo_full was low in
// the arbitration cycle; fullness is never re-checked once a grant is made.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_write,
    output logic [DATA_WIDTH-1:0]         o_fifo_data,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [ID_W-1:0]               o_grant_id,
    output logic [15:0]                   o_stall_cnt,
    output logic                          o_dbg_state
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic                    fifo_write_q, fifo_write_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q, fifo_data_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic [15:0]             stall_cnt_q, stall_cnt_d;

    logic                    win_found;
    logic [ID_W-1:0]         win_id;
    logic [ID_W-1:0]         cand;
    logic                    grant_ok;
    logic                    stall_hit;

    // Round-robin search from rr_ptr upward; scanning offsets high-to-low
    // lets the smallest asserted offset overwrite the rest and win.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (i_req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign grant_ok  = (state_q == ST_ARB) && i_enable && !i_fifo_full && win_found;
    assign stall_hit = (state_q == ST_ARB) && i_enable && i_fifo_full && (|i_req);

    // State register; reset always returns to arbitration.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a grant moves to WRITE, WRITE always falls back to ARB.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:   if (grant_ok) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    // Output/datapath next values: strobe and ack pulse only on a grant edge,
    // word and id hold otherwise, pointer advances past the winner on exit.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        fifo_write_d = 1'b0;
        fifo_data_d  = fifo_data_q;
        ack_d        = '0;
        grant_id_d   = grant_id_q;
        stall_cnt_d  = stall_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (grant_ok) begin
                    fifo_write_d = 1'b1;
                    fifo_data_d  = i_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
                    ack_d        = NUM_REQ'(1) << win_id;
                    grant_id_d   = win_id;
                end else if (stall_hit && (stall_cnt_q != 16'hFFFF)) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end
            ST_WRITE: begin
                if (grant_id_q == ID_W'(NUM_REQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_id_q + ID_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and pointer registers; reset clears any pending pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rr_ptr_q     <= '0;
            fifo_write_q <= 1'b0;
            fifo_data_q  <= '0;
            ack_q        <= '0;
            grant_id_q   <= '0;
            stall_cnt_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            fifo_write_q <= fifo_write_d;
            fifo_data_q  <= fifo_data_d;
            ack_q        <= ack_d;
            grant_id_q   <= grant_id_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign o_fifo_write = fifo_write_q;
    assign o_fifo_data  = fifo_data_q;
    assign o_ack        = ack_q;
    assign o_grant_id   = grant_id_q;
    assign o_stall_cnt  = stall_cnt_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios followed by random traffic,
// every cycle checked against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_enable;
  logic [NR-1:0]     i_req;
  logic [NR*DW-1:0]  i_data;
  logic              i_fifo_full;
  logic              o_fifo_write;
  logic [DW-1:0]     o_fifo_data;
  logic [NR-1:0]     o_ack;
  logic [IW-1:0]     o_grant_id;
  logic [15:0]       o_stall_cnt;
  logic              o_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // reference model state (plain integers)
  bit m_busy;
  int m_rr, m_write, m_data, m_ack, m_gid, m_stall;

  // clock / reset block
  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_req       (i_req),
    .i_data      (i_data),
    .i_fifo_full (i_fifo_full),
    .o_fifo_write(o_fifo_write),
    .o_fifo_data (o_fifo_data),
    .o_ack       (o_ack),
    .o_grant_id  (o_grant_id),
    .o_stall_cnt (o_stall_cnt),
    .o_dbg_state (o_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Behavioural rules: a grant takes one cycle to show, is followed by one
  // idle cycle, and the next search starts just after the last winner.
  task automatic model_update();
    int w;
    if (i_reset) begin
      m_busy = 0; m_rr = 0; m_write = 0; m_data = 0; m_ack = 0; m_gid = 0; m_stall = 0;
    end else if (m_busy) begin
      m_busy = 0; m_write = 0; m_ack = 0;
      m_rr = (m_gid + 1) % NR;
    end else if (i_enable && !i_fifo_full && i_req != 0) begin
      w = -1;
      for (int off = 0; off < NR; off++) begin
        if (w < 0 && i_req[(m_rr + off) % NR]) w = (m_rr + off) % NR;
      end
      m_busy = 1; m_write = 1; m_gid = w; m_ack = 1 << w;
      m_data = int'(i_data[w*DW +: DW]);
    end else begin
      m_write = 0; m_ack = 0;
      if (i_enable && i_fifo_full && i_req != 0 && m_stall < 65535) m_stall++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("write", 32'(o_fifo_write), 32'(m_write));
    check("data",  32'(o_fifo_data),  32'(m_data));
    check("ack",   32'(o_ack),        32'(m_ack));
    check("gid",   32'(o_grant_id),   32'(m_gid));
    check("stall", 32'(o_stall_cnt),  32'(m_stall));
    check("state", 32'(o_dbg_state),  32'(m_busy));
  endtask

  task automatic rand_data();
    for (int k = 0; k < NR; k++) i_data[k*DW +: DW] = DW'($urandom_range(0, 255));
  endtask

  initial begin
    int order;
    i_reset = 1'b1; i_enable = 1'b1; i_req = '0; i_data = '0; i_fifo_full = 1'b0;
    m_busy = 0; m_rr = 0; m_write = 0; m_data = 0; m_ack = 0; m_gid = 0; m_stall = 0;
    #2;
    step(); step();
    check("rst_write", 32'(o_fifo_write), 32'd0);
    check("rst_stall", 32'(o_stall_cnt), 32'd0);
    i_reset = 1'b0;

    // single request, word A5 on requester 2
    rand_data(); i_data[2*DW +: DW] = 8'hA5; i_req = 4'b0100;
    step();
    check("t1_write", 32'(o_fifo_write), 32'd1);
    check("t1_data",  32'(o_fifo_data), 32'hA5);
    check("t1_ack",   32'(o_ack), 32'b0100);
    check("t1_gid",   32'(o_grant_id), 32'd2);
    i_req = '0;
    step();
    check("t1_low", 32'(o_fifo_write), 32'd0);

    // all requesting: strict rotation, one write every two cycles
    i_reset = 1'b1; step(); i_reset = 1'b0;
    i_req = 4'b1111; order = 0;
    for (int i = 0; i < 16; i++) begin
      rand_data();
      step();
      check("rr_strobe", 32'(o_fifo_write), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (o_fifo_write) begin
        check("rr_order", 32'(o_grant_id), 32'(order % NR));
        order++;
      end
    end
    check("rr_count", 32'(order), 32'd8);

    // full FIFO stalls requester 0 for five cycles
    i_req = 4'b0001; i_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("full_nowr", 32'(o_fifo_write), 32'd0);
    end
    check("full_stall", 32'(o_stall_cnt), 32'd5);
    i_fifo_full = 1'b0;
    step();
    check("full_release", 32'(o_ack), 32'b0001);
    i_req = '0; step();

    // wrap-around after requester 3
    i_req = 4'b1000; step();
    check("wrap_g3", 32'(o_grant_id), 32'd3);
    i_req = 4'b1001; step(); step();
    check("wrap_g0", 32'(o_grant_id), 32'd0);
    i_req = '0; step();

    // enable low blocks grants; falling during WRITE does not cancel
    i_enable = 1'b0; i_req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_off", 32'(o_fifo_write), 32'd0);
    end
    i_enable = 1'b1; step();
    check("en_grant", 32'(o_ack), 32'b0010);
    i_enable = 1'b0; i_req = '0; step();
    check("en_done", 32'(o_fifo_write), 32'd0);
    step();
    check("en_idle", 32'(o_fifo_write), 32'd0);

    // reset in WRITE cancels everything and restarts search at 0
    i_enable = 1'b1; i_fifo_full = 1'b1; i_req = 4'b0100; step(); step();
    i_fifo_full = 1'b0; step();
    check("rw_grant", 32'(o_grant_id), 32'd2);
    i_reset = 1'b1; step();
    check("rw_write", 32'(o_fifo_write), 32'd0);
    check("rw_ack",   32'(o_ack), 32'd0);
    check("rw_stall", 32'(o_stall_cnt), 32'd0);
    i_reset = 1'b0; i_req = 4'b1111; step();
    check("rw_from0", 32'(o_grant_id), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      i_req       = NR'($urandom_range(0, 15));
      i_enable    = ($urandom_range(0, 9) < 8);
      i_fifo_full = ($urandom_range(0, 3) == 0);
      i_reset     = ($urandom_range(0, 49) == 0);
      rand_data();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
